// File: rtl/cache_ram_bridge.sv
// Cache line port to RAM FIFO bridge: one command per line, line serialised/deserialised in BUS_WIDTH beats.
// Optional stall timeout enabled by defining CACHE_RAM_BRIDGE_TIMEOUT_EN.
module cache_ram_bridge #(
    parameter int unsigned ADDR_SIZE      = 13,
    parameter int unsigned LINE_WIDTH     = 64,
    parameter int unsigned BUS_WIDTH      = 16,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk,
    input  logic                  not_reset,
    input  logic                  i_cache_avalid,
    input  logic                  i_cache_rnw,
    input  logic [ADDR_SIZE-1:0]  i_cache_addr,
    input  logic [LINE_WIDTH-1:0] i_cache_wdata,
    output logic [LINE_WIDTH-1:0] o_cache_rdata,
    output logic                  o_cache_ack,
    output logic                  o_cache_err,
    output logic                  o_busy,
    output logic                  o_cmd_valid,
    input  logic                  i_cmd_ready,
    output logic [ADDR_SIZE-1:0]  o_cmd_addr,
    output logic                  o_cmd_rnw,
    output logic                  o_wdata_valid,
    input  logic                  i_wdata_ready,
    output logic [BUS_WIDTH-1:0]  o_wdata,
    input  logic                  i_rdata_valid,
    output logic                  o_rdata_ready,
    input  logic [BUS_WIDTH-1:0]  i_rdata
);

    localparam int unsigned BEATS = LINE_WIDTH / BUS_WIDTH;
    localparam int unsigned CNT_W = (BEATS > 2) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_CMD      = 3'd1;
    localparam logic [2:0] S_WR_BEATS = 3'd2;
    localparam logic [2:0] S_RD_BEATS = 3'd3;
    localparam logic [2:0] S_ACK      = 3'd4;

    // Elaboration-time guard on the line/bus geometry and timeout limit
    if ((BUS_WIDTH == 0) || ((LINE_WIDTH % BUS_WIDTH) != 0) || (BEATS < 2) || (TIMEOUT_CYCLES == 0))
    begin : g_bad_params
        $error("cache_ram_bridge: invalid LINE_WIDTH/BUS_WIDTH/TIMEOUT_CYCLES");
    end

    logic [2:0]            r_state;
    logic [CNT_W-1:0]      r_cnt;
    logic [LINE_WIDTH-1:0] r_shift;
    logic                  r_cmd_valid;
    logic [ADDR_SIZE-1:0]  r_cmd_addr;
    logic                  r_cmd_rnw;
    logic                  r_wdata_valid;
    logic [BUS_WIDTH-1:0]  r_wdata;
    logic                  r_rdata_ready;
    logic [LINE_WIDTH-1:0] r_cache_rdata;
    logic                  r_cache_ack;
    logic                  r_cache_err;
    logic                  r_busy;

    logic [2:0]            w_state_next;
    logic [CNT_W-1:0]      w_cnt_next;
    logic [LINE_WIDTH-1:0] w_shift_next;
    logic                  w_cmd_valid_next;
    logic [ADDR_SIZE-1:0]  w_cmd_addr_next;
    logic                  w_cmd_rnw_next;
    logic                  w_wdata_valid_next;
    logic [BUS_WIDTH-1:0]  w_wdata_next;
    logic                  w_rdata_ready_next;
    logic [LINE_WIDTH-1:0] w_cache_rdata_next;
    logic                  w_cache_ack_next;
    logic                  w_cache_err_next;
    logic                  w_busy_next;

    logic                  w_cmd_xfer;
    logic                  w_wr_xfer;
    logic                  w_rd_xfer;
    logic                  w_last_beat;
    logic [LINE_WIDTH-1:0] w_shift_sr;
    logic [LINE_WIDTH-1:0] w_shift_in;
    logic                  w_timeout;

    assign w_cmd_xfer  = r_cmd_valid & i_cmd_ready;
    assign w_wr_xfer   = r_wdata_valid & i_wdata_ready;
    assign w_rd_xfer   = r_rdata_ready & i_rdata_valid;
    assign w_last_beat = (r_cnt == LAST_BEAT);
    assign w_shift_sr  = r_shift >> BUS_WIDTH;
    // Read beats enter at the top so beat 0 settles in the LSB slice
    assign w_shift_in  = {i_rdata, r_shift[LINE_WIDTH-1:BUS_WIDTH]};

`ifdef CACHE_RAM_BRIDGE_TIMEOUT_EN
    localparam int unsigned STALL_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [STALL_W-1:0] r_stall;
    logic [STALL_W-1:0] w_stall_next;
    logic               w_stalled;

    // A cycle is stalled when the handshake awaited in the current state does not happen
    assign w_stalled = ((r_state == S_CMD)      && !w_cmd_xfer) ||
                       ((r_state == S_WR_BEATS) && !w_wr_xfer)  ||
                       ((r_state == S_RD_BEATS) && !w_rd_xfer);
    assign w_timeout = w_stalled && (r_stall == STALL_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        w_stall_next = '0;
        if (w_stalled && !w_timeout) begin
            w_stall_next = r_stall + STALL_W'(1);
        end
    end

    always_ff @(posedge clk or negedge not_reset) begin
        if (!not_reset) begin
            r_stall <= '0;
        end else begin
            r_stall <= w_stall_next;
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    // Next-state and next-output logic
    always_comb begin
        w_state_next       = r_state;
        w_cnt_next         = r_cnt;
        w_shift_next       = r_shift;
        w_cmd_valid_next   = r_cmd_valid;
        w_cmd_addr_next    = r_cmd_addr;
        w_cmd_rnw_next     = r_cmd_rnw;
        w_wdata_valid_next = r_wdata_valid;
        w_wdata_next       = r_wdata;
        w_rdata_ready_next = r_rdata_ready;
        w_cache_rdata_next = r_cache_rdata;
        w_cache_ack_next   = 1'b0;
        w_cache_err_next   = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (i_cache_avalid) begin
                    w_state_next     = S_CMD;
                    w_cmd_valid_next = 1'b1;
                    w_cmd_addr_next  = i_cache_addr;
                    w_cmd_rnw_next   = i_cache_rnw;
                    w_cnt_next       = '0;
                    if (!i_cache_rnw) begin
                        w_shift_next = i_cache_wdata;
                    end
                end
            end
            S_CMD: begin
                if (w_cmd_xfer) begin
                    w_cmd_valid_next = 1'b0;
                    w_cnt_next       = '0;
                    if (r_cmd_rnw) begin
                        w_state_next       = S_RD_BEATS;
                        w_rdata_ready_next = 1'b1;
                    end else begin
                        w_state_next       = S_WR_BEATS;
                        w_wdata_valid_next = 1'b1;
                        w_wdata_next       = r_shift[BUS_WIDTH-1:0];
                    end
                end
            end
            S_WR_BEATS: begin
                if (w_wr_xfer) begin
                    w_shift_next = w_shift_sr;
                    w_wdata_next = w_shift_sr[BUS_WIDTH-1:0];
                    w_cnt_next   = r_cnt + CNT_W'(1);
                    if (w_last_beat) begin
                        w_wdata_valid_next = 1'b0;
                        w_state_next       = S_ACK;
                        w_cache_ack_next   = 1'b1;
                    end
                end
            end
            S_RD_BEATS: begin
                if (w_rd_xfer) begin
                    w_shift_next = w_shift_in;
                    w_cnt_next   = r_cnt + CNT_W'(1);
                    if (w_last_beat) begin
                        w_rdata_ready_next = 1'b0;
                        w_state_next       = S_ACK;
                        w_cache_ack_next   = 1'b1;
                        w_cache_rdata_next = w_shift_in;
                    end
                end
            end
            S_ACK: begin
                w_state_next = S_IDLE;
                w_cnt_next   = '0;
            end
            default: begin
                w_state_next = S_IDLE;
                w_cnt_next   = '0;
            end
        endcase

        // Abort: drop every handshake and complete with an error, leaving cache_rdata untouched
        if (w_timeout) begin
            w_state_next       = S_ACK;
            w_cnt_next         = '0;
            w_cmd_valid_next   = 1'b0;
            w_wdata_valid_next = 1'b0;
            w_rdata_ready_next = 1'b0;
            w_cache_rdata_next = r_cache_rdata;
            w_cache_ack_next   = 1'b1;
            w_cache_err_next   = 1'b1;
        end

        w_busy_next = (w_state_next != S_IDLE);
    end

    // State and output registers
    always_ff @(posedge clk or negedge not_reset) begin
        if (!not_reset) begin
            r_state       <= S_IDLE;
            r_cnt         <= '0;
            r_shift       <= '0;
            r_cmd_valid   <= 1'b0;
            r_cmd_addr    <= '0;
            r_cmd_rnw     <= 1'b0;
            r_wdata_valid <= 1'b0;
            r_wdata       <= '0;
            r_rdata_ready <= 1'b0;
            r_cache_rdata <= '0;
            r_cache_ack   <= 1'b0;
            r_cache_err   <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_cnt         <= w_cnt_next;
            r_shift       <= w_shift_next;
            r_cmd_valid   <= w_cmd_valid_next;
            r_cmd_addr    <= w_cmd_addr_next;
            r_cmd_rnw     <= w_cmd_rnw_next;
            r_wdata_valid <= w_wdata_valid_next;
            r_wdata       <= w_wdata_next;
            r_rdata_ready <= w_rdata_ready_next;
            r_cache_rdata <= w_cache_rdata_next;
            r_cache_ack   <= w_cache_ack_next;
            r_cache_err   <= w_cache_err_next;
            r_busy        <= w_busy_next;
        end
    end

    assign o_cache_rdata = r_cache_rdata;
    assign o_cache_ack   = r_cache_ack;
    assign o_cache_err   = r_cache_err;
    assign o_busy        = r_busy;
    assign o_cmd_valid   = r_cmd_valid;
    assign o_cmd_addr    = r_cmd_addr;
    assign o_cmd_rnw     = r_cmd_rnw;
    assign o_wdata_valid = r_wdata_valid;
    assign o_wdata       = r_wdata;
    assign o_rdata_ready = r_rdata_ready;

endmodule

// File: tb/tb_cache_ram_bridge.sv
// Directed bench for cache_ram_bridge: cycle-vector table for a plain write/read, then stall, reset and timeout sequences.
module tb_cache_ram_bridge;

    localparam int unsigned AW = 13;
    localparam int unsigned LW = 64;
    localparam int unsigned BW = 16;
    localparam int          NV = 17;

    localparam logic [LW-1:0] L1 = 64'h1111_2222_3333_4444;
    localparam logic [LW-1:0] LR = 64'hDDDD_CCCC_BBBB_AAAA;
    localparam logic [LW-1:0] LX = 64'hFFFF_0000_FFFF_0000;

    logic          clk = 1'b0;
    logic          not_reset;
    logic          cache_avalid;
    logic          cache_rnw;
    logic [AW-1:0] cache_addr;
    logic [LW-1:0] cache_wdata;
    logic [LW-1:0] cache_rdata;
    logic          cache_ack;
    logic          cache_err;
    logic          busy;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [AW-1:0] cmd_addr;
    logic          cmd_rnw;
    logic          wdata_valid;
    logic          wdata_ready;
    logic [BW-1:0] wdata;
    logic          rdata_valid;
    logic          rdata_ready;
    logic [BW-1:0] rdata;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    cache_ram_bridge #(
        .ADDR_SIZE      (AW),
        .LINE_WIDTH     (LW),
        .BUS_WIDTH      (BW),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk            (clk),
        .not_reset      (not_reset),
        .i_cache_avalid (cache_avalid),
        .i_cache_rnw    (cache_rnw),
        .i_cache_addr   (cache_addr),
        .i_cache_wdata  (cache_wdata),
        .o_cache_rdata  (cache_rdata),
        .o_cache_ack    (cache_ack),
        .o_cache_err    (cache_err),
        .o_busy         (busy),
        .o_cmd_valid    (cmd_valid),
        .i_cmd_ready    (cmd_ready),
        .o_cmd_addr     (cmd_addr),
        .o_cmd_rnw      (cmd_rnw),
        .o_wdata_valid  (wdata_valid),
        .i_wdata_ready  (wdata_ready),
        .o_wdata        (wdata),
        .i_rdata_valid  (rdata_valid),
        .o_rdata_ready  (rdata_ready),
        .i_rdata        (rdata)
    );

    typedef struct {
        logic          av;
        logic          rnw;
        logic [AW-1:0] addr;
        logic [LW-1:0] line;
        logic          crdy;
        logic          wrdy;
        logic          rvld;
        logic [BW-1:0] rd;
        logic          e_cv;
        logic [AW-1:0] e_ca;
        logic          e_crnw;
        logic          e_wv;
        logic [BW-1:0] e_wd;
        logic          e_rr;
        logic          e_ack;
        logic          e_busy;
        logic [LW-1:0] e_line;
    } vec_t;

    vec_t tbl [NV];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual %h required %h", nm, act, exp);
        end
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [LW-1:0] d);
        @(negedge clk);
        cache_avalid = 1'b1;
        cache_rnw    = 1'b0;
        cache_addr   = a;
        cache_wdata  = d;
        @(negedge clk);
        cache_avalid = 1'b0;
        chk("wr cmd_valid", 64'(cmd_valid), 64'(1));
        chk("wr cmd_addr", 64'(cmd_addr), 64'(a));
        chk("wr cmd_rnw", 64'(cmd_rnw), 64'(0));
        for (int b = 0; b < 4; b++) begin
            @(negedge clk);
            chk($sformatf("wr beat%0d valid", b), 64'(wdata_valid), 64'(1));
            chk($sformatf("wr beat%0d data", b), 64'(wdata), 64'(d[16*b +: 16]));
        end
        @(negedge clk);
        chk("wr ack", 64'(cache_ack), 64'(1));
        chk("wr err", 64'(cache_err), 64'(0));
        @(negedge clk);
        chk("wr idle busy", 64'(busy), 64'(0));
    endtask

    initial begin
        //         av rnw addr     line crdy wrdy rvld rd        cv  ca      crnw wv  wd        rr  ack busy line
        tbl[0]  = '{1, 0, 13'h0A5, L1,  1,   1,   0,   16'h0,    0,  13'h0,   0,  0,  16'h0,    0,  0,  0,   64'h0};
        tbl[1]  = '{0, 0, 13'h0,   0,   1,   1,   0,   16'h0,    1,  13'h0A5, 0,  0,  16'h0,    0,  0,  1,   64'h0};
        tbl[2]  = '{0, 0, 13'h0,   0,   1,   1,   0,   16'h0,    0,  13'h0A5, 0,  1,  16'h4444, 0,  0,  1,   64'h0};
        tbl[3]  = '{0, 0, 13'h0,   0,   1,   1,   0,   16'h0,    0,  13'h0A5, 0,  1,  16'h3333, 0,  0,  1,   64'h0};
        tbl[4]  = '{0, 0, 13'h0,   0,   1,   1,   0,   16'h0,    0,  13'h0A5, 0,  1,  16'h2222, 0,  0,  1,   64'h0};
        tbl[5]  = '{0, 0, 13'h0,   0,   1,   1,   0,   16'h0,    0,  13'h0A5, 0,  1,  16'h1111, 0,  0,  1,   64'h0};
        tbl[6]  = '{0, 0, 13'h0,   0,   1,   1,   0,   16'h0,    0,  13'h0A5, 0,  0,  16'h0,    0,  1,  1,   64'h0};
        tbl[7]  = '{1, 1, 13'h1FF, 0,   1,   1,   0,   16'h0,    0,  13'h0A5, 0,  0,  16'h0,    0,  0,  0,   64'h0};
        tbl[8]  = '{0, 0, 13'h0,   0,   1,   1,   0,   16'h0,    1,  13'h1FF, 1,  0,  16'h0,    0,  0,  1,   64'h0};
        tbl[9]  = '{0, 0, 13'h0,   0,   1,   1,   1,   16'hAAAA, 0,  13'h1FF, 1,  0,  16'h0,    1,  0,  1,   64'h0};
        tbl[10] = '{1, 0, 13'h055, LX,  1,   1,   1,   16'hBBBB, 0,  13'h1FF, 1,  0,  16'h0,    1,  0,  1,   64'h0};
        tbl[11] = '{0, 0, 13'h0,   0,   1,   1,   0,   16'h9999, 0,  13'h1FF, 1,  0,  16'h0,    1,  0,  1,   64'h0};
        tbl[12] = '{0, 0, 13'h0,   0,   1,   1,   1,   16'hCCCC, 0,  13'h1FF, 1,  0,  16'h0,    1,  0,  1,   64'h0};
        tbl[13] = '{0, 0, 13'h0,   0,   1,   1,   1,   16'hDDDD, 0,  13'h1FF, 1,  0,  16'h0,    1,  0,  1,   64'h0};
        tbl[14] = '{1, 0, 13'h055, LX,  1,   1,   0,   16'h0,    0,  13'h1FF, 1,  0,  16'h0,    0,  1,  1,   LR};
        tbl[15] = '{0, 0, 13'h0,   0,   1,   1,   0,   16'h0,    0,  13'h1FF, 1,  0,  16'h0,    0,  0,  0,   LR};
        tbl[16] = '{0, 0, 13'h0,   0,   1,   1,   0,   16'h0,    0,  13'h1FF, 1,  0,  16'h0,    0,  0,  0,   LR};

        not_reset    = 1'b0;
        cache_avalid = 1'b0;
        cache_rnw    = 1'b0;
        cache_addr   = '0;
        cache_wdata  = '0;
        cmd_ready    = 1'b0;
        wdata_ready  = 1'b0;
        rdata_valid  = 1'b0;
        rdata        = '0;
        repeat (3) @(negedge clk);
        not_reset = 1'b1;

        // Plain write then read with one read stall and ignored strobes
        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            chk($sformatf("v%0d cmd_valid", i), 64'(cmd_valid), 64'(tbl[i].e_cv));
            chk($sformatf("v%0d cmd_addr", i), 64'(cmd_addr), 64'(tbl[i].e_ca));
            chk($sformatf("v%0d cmd_rnw", i), 64'(cmd_rnw), 64'(tbl[i].e_crnw));
            chk($sformatf("v%0d wdata_valid", i), 64'(wdata_valid), 64'(tbl[i].e_wv));
            if (tbl[i].e_wv) begin
                chk($sformatf("v%0d wdata", i), 64'(wdata), 64'(tbl[i].e_wd));
            end
            chk($sformatf("v%0d rdata_ready", i), 64'(rdata_ready), 64'(tbl[i].e_rr));
            chk($sformatf("v%0d cache_ack", i), 64'(cache_ack), 64'(tbl[i].e_ack));
            chk($sformatf("v%0d cache_err", i), 64'(cache_err), 64'(0));
            chk($sformatf("v%0d busy", i), 64'(busy), 64'(tbl[i].e_busy));
            chk($sformatf("v%0d cache_rdata", i), cache_rdata, tbl[i].e_line);
            cache_avalid = tbl[i].av;
            cache_rnw    = tbl[i].rnw;
            cache_addr   = tbl[i].addr;
            cache_wdata  = tbl[i].line;
            cmd_ready    = tbl[i].crdy;
            wdata_ready  = tbl[i].wrdy;
            rdata_valid  = tbl[i].rvld;
            rdata        = tbl[i].rd;
        end

        // Command stall for 5 cycles, then write beats against a toggling wdata_ready
        begin
            logic [LW-1:0] sline;
            int beats;
            int acks;
            logic wr;
            sline = 64'hDEAD_BEEF_0123_4567;
            @(negedge clk);
            cache_avalid = 1'b1;
            cache_rnw    = 1'b0;
            cache_addr   = 13'h123;
            cache_wdata  = sline;
            cmd_ready    = 1'b0;
            wdata_ready  = 1'b0;
            rdata_valid  = 1'b0;
            for (int i = 0; i < 5; i++) begin
                @(negedge clk);
                cache_avalid = 1'b0;
                chk($sformatf("stall%0d cmd_valid", i), 64'(cmd_valid), 64'(1));
                chk($sformatf("stall%0d cmd_addr", i), 64'(cmd_addr), 64'(13'h123));
            end
            @(negedge clk);
            chk("stall cmd_valid held", 64'(cmd_valid), 64'(1));
            cmd_ready = 1'b1;
            beats = 0;
            acks  = 0;
            wr    = 1'b0;
            for (int c = 0; c < 20; c++) begin
                @(negedge clk);
                if (cmd_valid && (wdata_valid || rdata_ready)) begin
                    chk($sformatf("c%0d channel overlap", c), 64'(1), 64'(0));
                end
                if (cache_ack) begin
                    acks++;
                    chk($sformatf("c%0d stall err", c), 64'(cache_err), 64'(0));
                end
                if (wdata_valid) begin
                    if (beats < 4) begin
                        chk($sformatf("c%0d beat%0d data", c, beats), 64'(wdata), 64'(sline[16*beats +: 16]));
                    end else begin
                        chk($sformatf("c%0d extra beat", c), 64'(wdata_valid), 64'(0));
                    end
                end
                wr = ~wr;
                wdata_ready = wr;
                if (wdata_valid && wr) begin
                    beats++;
                end
            end
            chk("stall beat count", 64'(beats), 64'(4));
            chk("stall ack count", 64'(acks), 64'(1));
            chk("stall busy end", 64'(busy), 64'(0));
            wdata_ready = 1'b1;
        end

        // Asynchronous reset while beat 2 is on the bus, then a clean write
        @(negedge clk);
        cache_avalid = 1'b1;
        cache_rnw    = 1'b0;
        cache_addr   = 13'h0F0;
        cache_wdata  = 64'h5555_6666_7777_8888;
        @(negedge clk);
        cache_avalid = 1'b0;
        chk("rst pre cmd_valid", 64'(cmd_valid), 64'(1));
        @(negedge clk);
        chk("rst pre beat0", 64'(wdata), 64'(16'h8888));
        @(negedge clk);
        chk("rst pre beat1", 64'(wdata), 64'(16'h7777));
        @(negedge clk);
        chk("rst pre beat2", 64'(wdata), 64'(16'h6666));
        #2 not_reset = 1'b0;
        #1;
        chk("rst busy", 64'(busy), 64'(0));
        chk("rst wdata_valid", 64'(wdata_valid), 64'(0));
        chk("rst wdata", 64'(wdata), 64'(0));
        chk("rst cmd_valid", 64'(cmd_valid), 64'(0));
        chk("rst cmd_addr", 64'(cmd_addr), 64'(0));
        chk("rst rdata_ready", 64'(rdata_ready), 64'(0));
        chk("rst ack", 64'(cache_ack), 64'(0));
        chk("rst cache_rdata", cache_rdata, 64'h0);
        @(negedge clk);
        not_reset = 1'b1;
        do_write(13'h0AA, 64'h0102_0304_0506_0708);

`ifdef CACHE_RAM_BRIDGE_TIMEOUT_EN
        // Read whose data never arrives aborts after 8 stalled cycles
        begin
            int rr_cycles;
            bit got_ack;
            rr_cycles = 0;
            got_ack   = 1'b0;
            @(negedge clk);
            cache_avalid = 1'b1;
            cache_rnw    = 1'b1;
            cache_addr   = 13'h077;
            cmd_ready    = 1'b1;
            rdata_valid  = 1'b0;
            @(negedge clk);
            cache_avalid = 1'b0;
            chk("to cmd_valid", 64'(cmd_valid), 64'(1));
            for (int c = 0; c < 30 && !got_ack; c++) begin
                @(negedge clk);
                if (rdata_ready) begin
                    rr_cycles++;
                end
                if (cache_ack) begin
                    got_ack = 1'b1;
                    chk("to err", 64'(cache_err), 64'(1));
                    chk("to rdata_ready", 64'(rdata_ready), 64'(0));
                    chk("to cache_rdata", cache_rdata, 64'h0);
                end
            end
            chk("to ack seen", 64'(got_ack), 64'(1));
            chk("to stalled cycles", 64'(rr_cycles), 64'(8));
            @(negedge clk);
            chk("to busy end", 64'(busy), 64'(0));
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/cache_ram_bridge.md
Name: cache_ram_bridge

Overview:
Parametrised bridge between the cache line port and the RAM-side FIFO interface; generalises the fixed 4-beat cache-to-RAM controller.
- Line width and bus width are parameters; the beat count is derived from them.
- The line shift register is internal; all RAM-side links use valid/ready handshakes instead of raw FIFO flags.
- The cache issues one-cycle line read/write requests. The block serialises write lines to a write-data FIFO and deserialises read data from a read-data FIFO, issuing one address command per line.

Parameters:
ADDR_SIZE, 13, cache/RAM line address width
LINE_WIDTH, 64, cache line width in bits
BUS_WIDTH, 16, RAM data beat width; LINE_WIDTH must be an integer multiple, BEATS = LINE_WIDTH/BUS_WIDTH (>=2)
TIMEOUT_CYCLES, 1024, stall limit, used only with the optional feature

Ports:
clk  in  1  clock, rising edge
not_reset  in  1  asynchronous active-low reset
cache_avalid  in  1  one-cycle request strobe, honoured only when busy=0
cache_rnw  in  1  1=line read, 0=line write
cache_addr  in  ADDR_SIZE  line address
cache_wdata  in  LINE_WIDTH  write line, sampled with cache_avalid
cache_rdata  out  LINE_WIDTH  read line, valid when cache_ack=1
cache_ack  out  1  one-cycle completion pulse
cache_err  out  1  qualifies cache_ack: 1=aborted by timeout
busy  out  1  1 when state != IDLE
cmd_valid  out  1  command to RAM command FIFO
cmd_ready  in  1  command FIFO not full
cmd_addr  out  ADDR_SIZE  command address
cmd_rnw  out  1  command direction
wdata_valid  out  1  write beat valid
wdata_ready  in  1  write-data FIFO not full
wdata  out  BUS_WIDTH  write beat
rdata_valid  in  1  read-data FIFO not empty
rdata_ready  out  1  pop read beat
rdata  in  BUS_WIDTH  read beat

Behaviour:
- Reset: not_reset asynchronous, active-low; clock clk. All outputs are registered and reset to 0; state=IDLE; beat counter=0; shift register=0.
- States: IDLE, CMD, WR_BEATS, RD_BEATS, ACK.
- IDLE, cache_avalid=1: latch cache_addr and cache_rnw; if write, load cache_wdata into the shift register. Go to CMD with cmd_valid=1.
- CMD: hold cmd_valid/cmd_addr/cmd_rnw stable until cmd_ready=1 (transfer on valid&ready).
  - Transfer, write: go to WR_BEATS with wdata_valid=1, wdata = shift[BUS_WIDTH-1:0].
  - Transfer, read: go to RD_BEATS with rdata_ready=1.
- WR_BEATS: on each wdata_valid&wdata_ready, shift right by BUS_WIDTH and increment the counter. Beat 0 is the least-significant slice.
  - After beat BEATS-1 transfers: wdata_valid=0, go to ACK.
  - wdata_ready=0 stalls with data held.
- RD_BEATS: on each rdata_valid&rdata_ready, shift rdata into the MSB slice, shifting right, so beat 0 ends up in the LSB slice.
  - After beat BEATS-1: rdata_ready=0, go to ACK.
- ACK: cache_ack=1 for exactly one cycle. For reads, cache_rdata is updated in the same cycle and held until the next read completes; writes leave it unchanged. Next state IDLE, counter cleared.
- Latency with all ready signals held at 1: strobe at edge N; cmd_valid in cycle N+1; beats in cycles N+2..N+1+BEATS; cache_ack in cycle N+2+BEATS.
- cache_avalid while busy=1 (including the ACK cycle) is ignored; no queueing.
- Mid-transfer reset clears the state immediately; partial beats already sent are not recalled.
- cmd and data channels are never active in the same cycle.

Optional Feature:
Macro CACHE_RAM_BRIDGE_TIMEOUT_EN.
- Defined: a stall counter increments each cycle in CMD/WR_BEATS/RD_BEATS where the awaited handshake does not occur, and clears on any transfer.
  - When it reaches TIMEOUT_CYCLES, drop all valid/ready outputs and go to ACK with cache_ack=1 and cache_err=1; cache_rdata is not updated.
  - Counter width is $clog2(TIMEOUT_CYCLES+1).
- Undefined: no counter logic; cache_err tied to 0; stalls wait indefinitely.

Test Plan:
- Write, all ready=1, addr 0x0A5, wdata 0x1111_2222_3333_4444 -> cmd 0x0A5/rnw=0 in 1 cycle; wdata beats 0x4444, 0x3333, 0x2222, 0x1111; ack at N+6, err=0.
- Read addr 0x1FF, rdata beats 0xAAAA, 0xBBBB, 0xCCCC, 0xDDDD -> cache_rdata=0xDDDD_CCCC_BBBB_AAAA with ack pulse of width 1.
- cmd_ready low 5 cycles, then wdata_ready toggling every cycle -> cmd_addr and wdata held stable while stalled; exactly 4 beats, no duplicates; ack once.
- Second cache_avalid strobe during RD_BEATS and during the ACK cycle -> ignored; no extra cmd_valid.
- not_reset asserted during WR_BEATS beat 2 -> all outputs 0 asynchronously, busy=0; next request proceeds normally from beat 0.
- With CACHE_RAM_BRIDGE_TIMEOUT_EN, TIMEOUT_CYCLES=8, rdata_valid stuck at 0 -> cache_ack with cache_err=1 after 8 stalled cycles; cache_rdata unchanged.
